// File: rtl/fir_interp_pkg.sv
// rtl/fir_interp_pkg.sv - coefficient table, state enum and sum-to-output mapping for fir_interp
// Build option FIR_INTERP_SAT_EN: saturate (rather than wrap) when the output is narrower than the sum.
package fir_interp_pkg;

  localparam int NTAPS = 16;
  localparam int ACC_W = 26;

  localparam logic signed [7:0] COEF [0:NTAPS-1] = '{
    8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd5, 8'sd6, 8'sd7, 8'sd8,
    8'sd8, 8'sd7, 8'sd6, 8'sd5, 8'sd4, 8'sd3, 8'sd2, 8'sd1
  };

  typedef enum logic {IDLE, PHASE} state_t;

  // Result is still ACC_W wide; the caller takes the low bits (or sign-extends).
  function automatic logic signed [ACC_W-1:0] fit_out(input logic signed [ACC_W-1:0] s,
                                                      input int width);
`ifdef FIR_INTERP_SAT_EN
    logic signed [ACC_W-1:0] hi;
    logic signed [ACC_W-1:0] lo;
    if (width >= ACC_W) return s;
    hi = ACC_W'((64'sd1 <<< (width - 1)) - 64'sd1);
    lo = ~hi;
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
`else
    if (width >= ACC_W) return s;
    return (s <<< (ACC_W - width)) >>> (ACC_W - width);
`endif
  endfunction

endpackage

// File: rtl/fir_interp_mac.sv
// rtl/fir_interp_mac.sv - combinational TPP-tap dot product for one polyphase branch
module fir_interp_mac
  import fir_interp_pkg::*;
#(
  parameter int N1  = 8,
  parameter int N2  = 16,
  parameter int L   = 4,
  parameter int TPP = 4
) (
  input  logic [1:0]         phase,
  input  logic [TPP*N2-1:0]  taps,
  output logic [ACC_W-1:0]   sum
);

  logic signed [ACC_W-1:0] acc;

  always_comb begin
    logic signed [N1+N2-1:0] prod;
    logic [3:0]              idx;
    acc  = '0;
    prod = '0;
    idx  = '0;
    // Phase p uses every L-th coefficient starting at p.
    for (int k = 0; k < TPP; k++) begin
      idx  = 4'(k * L + int'(phase));
      prod = COEF[idx] * $signed(taps[k*N2 +: N2]);
      acc  = acc + ACC_W'(prod);
    end
  end

  assign sum = acc;

endmodule

// File: rtl/fir_interp.sv
// rtl/fir_interp.sv - polyphase upsample-by-L interpolating FIR (16 taps)
// Build option FIR_INTERP_SAT_EN selects saturation when N3 is narrower than the sum.
module fir_interp
  import fir_interp_pkg::*;
#(
  parameter int N1  = 8,
  parameter int N2  = 16,
  parameter int N3  = 32,
  parameter int L   = 4,
  parameter int TPP = 4
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          ENABLE,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N2-1:0] input_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N3-1:0] filtered_data,
  output logic [N2-1:0] sample_T,
  output logic [1:0]    phase
);

  state_t state, state_next;

  logic [TPP*N2-1:0] x;
  logic [TPP*N2-1:0] x_shift;
  logic [TPP*N2-1:0] mac_taps;
  logic [1:0]        mac_phase;
  logic [ACC_W-1:0]  mac_sum;
  logic              last_phase;
  logic              acc_in;
  logic              acc_out;
  logic              do_shift;
  logic              do_advance;
  logic              do_drain;

  assign last_phase = (phase == 2'(L - 1));
  // Combinational from out_ready so back-to-back inputs stream at exactly L cycles each.
  assign in_ready   = ENABLE && (state == IDLE || (state == PHASE && last_phase && out_ready));
  assign acc_in     = ENABLE && in_valid && in_ready;
  assign acc_out    = ENABLE && out_valid && out_ready;

  assign x_shift    = {x[(TPP-1)*N2-1:0], input_data};
  assign mac_taps   = acc_in ? x_shift : x;
  assign mac_phase  = acc_in ? 2'd0 : phase + 2'd1;

  fir_interp_mac #(
    .N1  (N1),
    .N2  (N2),
    .L   (L),
    .TPP (TPP)
  ) u_mac (
    .phase (mac_phase),
    .taps  (mac_taps),
    .sum   (mac_sum)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    do_shift   = 1'b0;
    do_advance = 1'b0;
    do_drain   = 1'b0;
    case (state)
      IDLE: begin
        if (acc_in) begin
          do_shift   = 1'b1;
          state_next = PHASE;
        end
      end
      PHASE: begin
        if (acc_out) begin
          if (!last_phase) begin
            do_advance = 1'b1;
          end else if (acc_in) begin
            do_shift = 1'b1;
          end else begin
            do_drain   = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x             <= '0;
      sample_T      <= '0;
      filtered_data <= '0;
      phase         <= 2'd0;
      out_valid     <= 1'b0;
    end else if (do_shift) begin
      x             <= x_shift;
      sample_T      <= input_data;
      filtered_data <= N3'(fit_out($signed(mac_sum), N3));
      phase         <= 2'd0;
      out_valid     <= 1'b1;
    end else if (do_advance) begin
      filtered_data <= N3'(fit_out($signed(mac_sum), N3));
      phase         <= phase + 2'd1;
    end else if (do_drain) begin
      out_valid     <= 1'b0;
    end
  end

endmodule
